// File: rtl/uart_program_loader.sv
// uart_program_loader: turns 'L' count data... UART byte stream into instruction-memory word writes, 'R' releases cpu_hold
// Ports: clk, reset (sync, active-high); rx_data/rx_done_tick from uart_rx;
//        mem_we/mem_addr/mem_wdata to instruction memory write port;
//        cpu_hold to pipeline; busy, load_done_tick, load_error status.
module uart_program_loader #(
  parameter int          ADDR_W      = 11,
  parameter int          TIMEOUT_CYC = 2000000,
  parameter int          TO_BIT      = 21,
  parameter logic [7:0]  LOAD_CMD    = 8'h4C,
  parameter logic [7:0]  RUN_CMD     = 8'h52
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done_tick,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done_tick,
  output logic              load_error
);
  typedef enum logic [1:0] {IDLE, CNT_HI, CNT_LO, DATA} state_t;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
  state_t            state;
  logic [7:0]        cnt_hi;
  logic [15:0]       words_left;
  logic [1:0]        byte_idx;
  logic [23:0]       word;
  logic [TO_BIT-1:0] timer;
  logic [15:0]       count;
  logic              count_bad;
  assign count     = {cnt_hi, rx_data};
  assign count_bad = (count == 16'd0) || ({1'b0, count} > MAX_WORDS);
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt_hi         <= '0;
      words_left     <= '0;
      byte_idx       <= '0;
      word           <= '0;
      timer          <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      cpu_hold       <= 1'b0;
      busy           <= 1'b0;
      load_done_tick <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      mem_we         <= 1'b0;
      load_done_tick <= 1'b0;
      // address advances in the cycle after each write; a LOAD_CMD below overrides it
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (state == IDLE) begin
        // busy is held through the final-write cycle, then dropped here
        busy <= 1'b0;
        if (rx_done_tick && rx_data == LOAD_CMD) begin
          state      <= CNT_HI;
          cpu_hold   <= 1'b1;
          load_error <= 1'b0;
          mem_addr   <= '0;
          timer      <= '0;
          busy       <= 1'b1;
        end else if (rx_done_tick && rx_data == RUN_CMD) begin
          cpu_hold <= 1'b0;
        end
      end else if (rx_done_tick) begin
        timer <= '0;
        case (state)
          CNT_HI: begin
            cnt_hi <= rx_data;
            state  <= CNT_LO;
          end
          CNT_LO: begin
            if (count_bad) begin
              load_error <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              words_left <= count;
              byte_idx   <= '0;
              state      <= DATA;
            end
          end
          default: begin
            word     <= {word[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we     <= 1'b1;
              mem_wdata  <= {word, rx_data};
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) begin
                load_done_tick <= 1'b1;
                state          <= IDLE;
              end
            end
          end
        endcase
      end else if (timer == TO_BIT'(TIMEOUT_CYC - 1)) begin
        load_error <= 1'b1;
        state      <= IDLE;
        busy       <= 1'b0;
        timer      <= '0;
      end else begin
        timer <= timer + TO_BIT'(1);
      end
    end
  end
endmodule
